// File: rtl/local_store_responder_if.sv
// ---------------------------------------------------------------------------
// local_store_responder_if
// Bundles the odd-pipe <-> local-store request/response signals.
//   master : drives LS requests, flush; receives load returns
//   slave  : the local store itself
// Signals (big-endian bit numbering, bit 0 = MSB):
//   LS_valid_input, LS_write_enable_input, LS_address_input[0:ADDR_W-1],
//   LS_data_input[0:127], rt_address_input[0:6], flush_input
//   LS_data_output[0:127], LS_data_valid_output, rt_address_output[0:6]
// Optional (macro LS_PARITY_EN): LS_parity_inject_input[0:15],
//   LS_parity_error_output.
// ---------------------------------------------------------------------------
interface local_store_responder_if #(
    parameter int ADDR_W = 15
);
    logic               LS_valid_input;
    logic               LS_write_enable_input;
    logic [0:ADDR_W-1]  LS_address_input;
    logic [0:127]       LS_data_input;
    logic [0:6]         rt_address_input;
    logic               flush_input;
    logic [0:127]       LS_data_output;
    logic               LS_data_valid_output;
    logic [0:6]         rt_address_output;
`ifdef LS_PARITY_EN
    logic [0:15]        LS_parity_inject_input;
    logic               LS_parity_error_output;

    modport master (
        output LS_valid_input, LS_write_enable_input, LS_address_input,
               LS_data_input, rt_address_input, flush_input, LS_parity_inject_input,
        input  LS_data_output, LS_data_valid_output, rt_address_output,
               LS_parity_error_output
    );
    modport slave (
        input  LS_valid_input, LS_write_enable_input, LS_address_input,
               LS_data_input, rt_address_input, flush_input, LS_parity_inject_input,
        output LS_data_output, LS_data_valid_output, rt_address_output,
               LS_parity_error_output
    );
`else
    modport master (
        output LS_valid_input, LS_write_enable_input, LS_address_input,
               LS_data_input, rt_address_input, flush_input,
        input  LS_data_output, LS_data_valid_output, rt_address_output
    );
    modport slave (
        input  LS_valid_input, LS_write_enable_input, LS_address_input,
               LS_data_input, rt_address_input, flush_input,
        output LS_data_output, LS_data_valid_output, rt_address_output
    );
`endif
endinterface

// File: rtl/local_store_responder.sv
// ---------------------------------------------------------------------------
// local_store_responder
// Single-ported 128-bit quadword local store serving the odd pipe.
// Loads read the array on the accepting edge and travel a LATENCY-deep
// valid/data/tag pipeline; the result is registered on the outputs exactly
// LATENCY edges after acceptance. Stores write on the accepting edge and
// produce no response. flush_input kills every in-flight load (including
// one arriving that cycle); stores still commit.
// Ports:
//   clock  : single clock, posedge
//   reset  : asynchronous, active-high
//   ls     : local_store_responder_if.slave (request/response bundle)
// Parameters: DEPTH_QW (quadwords), ADDR_W (byte address bits),
//   LATENCY (1..8).
// Optional feature macro: LS_PARITY_EN -- per-byte even parity stored with
//   each quadword, inject on store, error flag alongside the load return.
// ---------------------------------------------------------------------------
module local_store_responder #(
    parameter int DEPTH_QW = 2048,
    parameter int ADDR_W   = 15,
    parameter int LATENCY  = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    local_store_responder_if.slave ls
);
    localparam int IDX_W = ADDR_W - 4;

    logic [0:IDX_W-1] w_idx;
    logic             w_store;
    logic             w_load;
    logic             w_fire;
    logic             w_unused;

    // Low 4 address bits select a byte inside the quadword and are ignored.
    assign w_idx    = ls.LS_address_input[0:IDX_W-1];
    assign w_unused = &{1'b0, ls.LS_address_input[IDX_W:ADDR_W-1]};
    assign w_store  = ls.LS_valid_input &  ls.LS_write_enable_input;
    assign w_load   = ls.LS_valid_input & ~ls.LS_write_enable_input & ~ls.flush_input;

    logic [0:127] r_mem      [0:DEPTH_QW-1];
    logic [0:127] r_dat_pipe [1:LATENCY];
    logic [0:6]   r_tag_pipe [1:LATENCY];
    logic [1:LATENCY] r_vld_pipe;

    logic [0:127] r_data_out;
    logic [0:6]   r_tag_out;
    logic         r_valid_out;

    // A load completing in the same cycle as a flush is dropped too.
    assign w_fire = r_vld_pipe[LATENCY] & ~ls.flush_input;

    always_ff @(posedge clock) begin
        if (w_store)
            r_mem[w_idx] <= ls.LS_data_input;
    end

    // Data/tag stages carry no reset; only the valid bits matter.
    always_ff @(posedge clock) begin
        if (w_load) begin
            r_dat_pipe[1] <= r_mem[w_idx];
            r_tag_pipe[1] <= ls.rt_address_input;
        end
        for (int s = 2; s <= LATENCY; s++) begin
            r_dat_pipe[s] <= r_dat_pipe[s-1];
            r_tag_pipe[s] <= r_tag_pipe[s-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
        end else if (ls.flush_input) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_load;
            for (int s = 2; s <= LATENCY; s++)
                r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
    end

    // Outputs hold their last returned values while not valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_out  <= '0;
            r_tag_out   <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_fire;
            if (w_fire) begin
                r_data_out <= r_dat_pipe[LATENCY];
                r_tag_out  <= r_tag_pipe[LATENCY];
            end
        end
    end

    assign ls.LS_data_output       = r_data_out;
    assign ls.rt_address_output    = r_tag_out;
    assign ls.LS_data_valid_output = r_valid_out;

`ifdef LS_PARITY_EN
    logic [0:15] r_par_mem  [0:DEPTH_QW-1];
    logic [0:15] r_par_pipe [1:LATENCY];
    logic [0:15] w_par_wr;
    logic [0:15] w_par_bad;
    logic        r_perr_out;

    // Stored bit = XOR of the byte, so byte plus parity has even weight;
    // a mismatch is the XOR of the recomputed and stored bits.
    for (genvar b = 0; b < 16; b++) begin : g_par
        assign w_par_wr[b]  = (^ls.LS_data_input[8*b +: 8]) ^ ls.LS_parity_inject_input[b];
        assign w_par_bad[b] = (^r_dat_pipe[LATENCY][8*b +: 8]) ^ r_par_pipe[LATENCY][b];
    end

    always_ff @(posedge clock) begin
        if (w_store)
            r_par_mem[w_idx] <= w_par_wr;
        if (w_load)
            r_par_pipe[1] <= r_par_mem[w_idx];
        for (int s = 2; s <= LATENCY; s++)
            r_par_pipe[s] <= r_par_pipe[s-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_perr_out <= 1'b0;
        else
            r_perr_out <= w_fire & (|w_par_bad);
    end

    assign ls.LS_parity_error_output = r_perr_out;
`endif
endmodule

// File: tb/tb_local_store_responder.sv
module tb_local_store_responder;
    localparam int LAT = 6;

    typedef struct {
        logic [0:127] data;
        logic [0:6]   tag;
        int           due;
        logic         perr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    local_store_responder_if #(.ADDR_W(15)) ls ();

    local_store_responder #(.DEPTH_QW(2048), .ADDR_W(15), .LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .ls    (ls)
    );

    exp_t         q[$];
    logic [0:127] mm[int];
    logic         pm[int];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    logic         started = 1'b0;
    logic [0:127] last_d = '0;
    logic [0:6]   last_t = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One request per call: drive away from the edge, then update the model.
    task automatic step(input logic v, input logic we, input logic [0:14] a,
                        input logic [0:127] d, input logic [0:6] t,
                        input logic fl, input logic [0:15] inj);
        int idx;
        @(negedge clock);
        ls.LS_valid_input        = v;
        ls.LS_write_enable_input = we;
        ls.LS_address_input      = a;
        ls.LS_data_input         = d;
        ls.rt_address_input      = t;
        ls.flush_input           = fl;
`ifdef LS_PARITY_EN
        ls.LS_parity_inject_input = inj;
`endif
        @(posedge clock);
        cyc++;
        idx = int'(a) / 16;
        if (v && we) begin
            mm[idx] = d;
            pm[idx] = (inj != 16'h0);
        end
        if (fl) q.delete();
        if (v && !we && !fl)
            q.push_back('{data: mm[idx], tag: t, due: cyc + LAT, perr: pm[idx]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic st(input logic [0:14] a, input logic [0:127] d);
        step(1'b1, 1'b1, a, d, '0, 1'b0, '0);
    endtask

    task automatic ld(input logic [0:14] a, input logic [0:6] t);
        step(1'b1, 1'b0, a, '0, t, 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {127'd0, ls.LS_data_valid_output}, 128'd0);
        check("rst_data", ls.LS_data_output, 128'd0);
        check("rst_tag", {121'd0, ls.rt_address_output}, 128'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (started && !reset) begin
            if (ls.LS_data_valid_output) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 tag=%0d expected no return (cycle %0d)",
                             ls.rt_address_output, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ret_cycle", 128'(cyc), 128'(e.due));
                    check("ret_data", ls.LS_data_output, e.data);
                    check("ret_tag", {121'd0, ls.rt_address_output}, {121'd0, e.tag});
`ifdef LS_PARITY_EN
                    check("ret_perr", {127'd0, ls.LS_parity_error_output}, {127'd0, e.perr});
`endif
                    last_d = e.data;
                    last_t = e.tag;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_return: got valid=0 expected tag %0d due cycle %0d (cycle %0d)",
                             q[0].tag, q[0].due, cyc);
                    void'(q.pop_front());
                end
                check("hold_data", ls.LS_data_output, last_d);
                check("hold_tag", {121'd0, ls.rt_address_output}, {121'd0, last_t});
            end
        end
    end

    initial begin
        logic [0:127] da, db;
        ls.LS_valid_input = 1'b0;
        ls.LS_write_enable_input = 1'b0;
        ls.LS_address_input = '0;
        ls.LS_data_input = '0;
        ls.rt_address_input = '0;
        ls.flush_input = 1'b0;
`ifdef LS_PARITY_EN
        ls.LS_parity_inject_input = '0;
`endif
        repeat (2) @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        started = 1'b1;

        // Basic store then load, tag 5.
        st(15'h0010, 128'h0123456789ABCDEF0123456789ABCDEF);
        ld(15'h0010, 7'd5);
        idle(LAT + 1);

        // Low address bits ignored.
        st(15'h0020, 128'hDEADBEEF_00112233_44556677_8899AABB);
        ld(15'h002F, 7'd7);
        idle(LAT + 1);

        // Back-to-back loads, in order, no bubbles.
        st(15'h0000, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
        ld(15'h0000, 7'd1);
        ld(15'h0010, 7'd2);
        ld(15'h0020, 7'd3);
        idle(LAT + 1);

        // Data captured at acceptance: load returns old value, later load new.
        da = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        db = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        st(15'h0040, da);
        ld(15'h0040, 7'd9);
        st(15'h0040, db);
        idle(LAT + 1);
        ld(15'h0040, 7'd10);
        idle(LAT + 1);

        // Flush two cycles after three loads: nothing returns.
        ld(15'h0000, 7'd11);
        ld(15'h0010, 7'd12);
        ld(15'h0020, 7'd13);
        idle(1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, '0);
        idle(LAT + 2);

        // Load with flush is dropped; store with flush commits.
        ld(15'h0010, 7'd20);
        step(1'b1, 1'b0, 15'h0020, '0, 7'd21, 1'b1, '0);
        step(1'b1, 1'b1, 15'h0050, 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, '0, 1'b1, '0);
        ld(15'h0050, 7'd22);
        idle(LAT + 1);

        // Loads in flight killed by reset; outputs return to zero.
        ld(15'h0000, 7'd30);
        ld(15'h0010, 7'd31);
        ld(15'h0020, 7'd32);
        @(posedge clock);
        #2;
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        check_reset_outputs();
        idle(2);
        @(negedge clock);
        reset = 1'b0;
        last_d = '0;
        last_t = '0;
        idle(LAT + 2);

`ifdef LS_PARITY_EN
        st(15'h0060, 128'h00FF00FF_12345678_0F0F0F0F_87654321);
        step(1'b1, 1'b1, 15'h0070, 128'h00FF00FF_12345678_0F0F0F0F_87654321, '0, 1'b0, 16'h8000);
        ld(15'h0060, 7'd40);
        ld(15'h0070, 7'd41);
        idle(LAT + 1);
`endif

        // Randomized traffic over a pre-written set of quadwords.
        for (int k = 0; k < 16; k++)
            st(15'((k * 100 + 3) * 16), {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 400; i++) begin
            logic v, we, fl;
            logic [0:14] a;
            v  = ($urandom % 4) != 0;
            we = ($urandom % 3) == 0;
            fl = ($urandom % 25) == 0;
            a  = 15'(($urandom_range(0, 15) * 100 + 3) * 16 + $urandom_range(0, 15));
            step(v, we, a, {$urandom, $urandom, $urandom, $urandom}, 7'($urandom), fl, '0);
        end
        idle(LAT + 3);
        check("drained", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
